// File: rtl/seq_frame_gen_1101.sv
// rtl/seq_frame_gen_1101.sv - serial frame transmitter: sync word, payload, optional even parity, guard zeros
module seq_frame_gen_1101 #(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC         = 4'b1101,
    parameter int                DATA_W       = 8,
    parameter int                PARITY_EN    = 1,
    parameter int                GUARD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              x_out,
    output logic              frame_valid,
    output logic              sync_phase,
    output logic              done
);

    localparam int SR_W   = SYNC_W + DATA_W;
    localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAXC   = (MAX_SD > GUARD_CYCLES) ? MAX_SD : GUARD_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PAR,
        ST_GUARD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              par_q, par_d;
    logic              x_q, x_d;
    logic              fv_q, fv_d;
    logic              sp_q, sp_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            x_q     <= 1'b0;
            fv_q    <= 1'b0;
            sp_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            x_q     <= x_d;
            fv_q    <= fv_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Outputs are computed one edge ahead so that every port is a flop.
    // The shift register holds the remaining sync and payload bits, MSB next.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        par_d   = par_q;
        x_d     = 1'b0;
        fv_d    = 1'b0;
        sp_d    = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d = ST_SYNC;
                    cnt_d   = CW'(SYNC_W - 1);
                    sr_d    = {SYNC[SYNC_W-2:0], data_in, 1'b0};
                    par_d   = ^data_in;
                    x_d     = SYNC[SYNC_W-1];
                    fv_d    = 1'b1;
                    sp_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_SYNC: begin
                x_d  = sr_q[SR_W-1];
                sr_d = {sr_q[SR_W-2:0], 1'b0};
                fv_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = CW'(DATA_W - 1);
                    done_d  = (DATA_W == 1) && (PARITY_EN == 0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    sp_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    if (PARITY_EN != 0) begin
                        state_d = ST_PAR;
                        x_d     = par_q;
                        fv_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = CW'(GUARD_CYCLES - 1);
                    end
                end else begin
                    x_d    = sr_q[SR_W-1];
                    sr_d   = {sr_q[SR_W-2:0], 1'b0};
                    fv_d   = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                    done_d = (cnt_q == CW'(1)) && (PARITY_EN == 0);
                end
            end
            ST_PAR: begin
                state_d = ST_GUARD;
                cnt_d   = CW'(GUARD_CYCLES - 1);
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready       = ready_q;
    assign x_out       = x_q;
    assign frame_valid = fv_q;
    assign sync_phase  = sp_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_frame_gen_1101.sv
// tb/tb_seq_frame_gen_1101.sv - scoreboard bench for seq_frame_gen_1101 (parity and no-parity instances)
module tb_seq_frame_gen_1101;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [7:0] data1, data2;
    logic       ready1, x1, fv1, sp1, dn1;
    logic       ready2, x2, fv2, sp2, dn2;

    typedef struct {
        logic x;
        logic sp;
        logic dn;
        int   cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   done_cnt1 = 0;
    bit   mon_en = 1'b0;

    seq_frame_gen_1101 dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .ready(ready1), .x_out(x1), .frame_valid(fv1), .sync_phase(sp1), .done(dn1)
    );

    seq_frame_gen_1101 #(.PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_in(data2),
        .ready(ready2), .x_out(x2), .frame_valid(fv2), .sync_phase(sp2), .done(dn2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int which, input logic [12:0] bits, input int len, input int c0);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.x   = bits[len-1-i];
            e.sp  = (i < 4);
            e.dn  = (i == len - 1);
            e.cyc = c0 + i;
            if (which == 1) q1.push_back(e);
            else            q2.push_back(e);
        end
    endtask

    task automatic mon(input int which, input logic fv, input logic x, input logic sp, input logic dn);
        exp_t e;
        int   n;
        n = (which == 1) ? q1.size() : q2.size();
        if (fv) begin
            chk((which == 1) ? "dut1_frame_bit_expected" : "dut2_frame_bit_expected", (n != 0), 1);
            if (n != 0) begin
                e = (which == 1) ? q1.pop_front() : q2.pop_front();
                chk((which == 1) ? "dut1_bit{x,sync,done,cycle}" : "dut2_bit{x,sync,done,cycle}",
                    {x, sp, dn, 32'(cyc)}, {e.x, e.sp, e.dn, 32'(e.cyc)});
            end
        end else begin
            chk((which == 1) ? "dut1_idle{x,sync,done}" : "dut2_idle{x,sync,done}", {x, sp, dn}, 3'b000);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, fv1, x1, sp1, dn1);
            mon(2, fv2, x2, sp2, dn2);
            if (dn1 === 1'b1) done_cnt1++;
        end
    end

    task automatic issue(input bit on1, input bit on2, input logic [7:0] d,
                         input logic [12:0] exp1, input logic [12:0] exp2);
        int c0;
        if (on1) begin chk("dut1_ready_before_start", ready1, 1); start1 = 1'b1; data1 = d; end
        if (on2) begin chk("dut2_ready_before_start", ready2, 1); start2 = 1'b1; data2 = d; end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        c0 = cyc;
        if (on1) push(1, exp1, 13, c0);
        if (on2) push(2, exp2, 12, c0);
    endtask

    initial begin
        int d0;
        int c0;
        rst = 1'b1; start1 = 1'b1; start2 = 1'b1; data1 = 8'hFF; data2 = 8'hFF;

        // Reset held for two edges with start asserted
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_dut1{x,ready,fv,done}", {x1, ready1, fv1, dn1}, 4'b0100);
        chk("rst_dut2{x,ready,fv,done}", {x2, ready2, fv2, dn2}, 4'b0100);
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single default frame A5, ready returns in cycle 16
        issue(1, 0, 8'hA5, 13'b1101_1010_0101_0, 13'b0);
        repeat (15) @(negedge clk);
        chk("a5_ready_last_guard", ready1, 0);
        @(negedge clk);
        chk("a5_ready_cycle16", ready1, 1);
        repeat (3) @(posedge clk);
        #1;

        // Parity bit 1 on 07; 12-bit frame without parity
        issue(1, 1, 8'h07, 13'b1101_0000_0111_1, 13'b0_1101_0000_0111);
        repeat (20) @(posedge clk);
        #1;

        // Busy request is ignored
        issue(1, 0, 8'h3C, 13'b1101_0011_1100_0, 13'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_ready_low", ready1, 0);
        start1 = 1'b1; data1 = 8'hFF;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Back-to-back with start held high
        d0 = done_cnt1;
        chk("b2b_ready", ready1, 1);
        start1 = 1'b1; data1 = 8'h81;
        @(posedge clk);
        #1 c0 = cyc;
        push(1, 13'b1101_1000_0001_0, 13, c0);
        repeat (16) @(posedge clk);
        #1 c0 = cyc;
        push(1, 13'b1101_1000_0001_0, 13, c0);
        start1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_done_count", done_cnt1 - d0, 2);

        // Reset during data bit 3 (frame bit 7)
        d0 = done_cnt1;
        issue(1, 0, 8'hA5, 13'b1101_1010_0101_0, 13'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready1", ready1, 1);
        chk("midrst_ready2", ready2, 1);
        chk("midrst_no_done", done_cnt1 - d0, 0);
        @(posedge clk);
        #1;
        issue(1, 0, 8'hA5, 13'b1101_1010_0101_0, 13'b0);
        repeat (20) @(posedge clk);
        #1;

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
